// File: rtl/snake_pkg.sv
// Shared types and playfield geometry for the snake game blocks.
// Also used by the apple placer and the drawing logic.
package snake_pkg;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [31:0] CELL     = 32'd32;
  localparam logic [31:0] SCREEN_W = 32'd640;
  localparam logic [31:0] SCREEN_H = 32'd480;

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_head_ctrl_if.sv
// Control-side bundle of the snake head: button requests and apple position in,
// head position and game status out.
interface snake_head_ctrl_if;
  import snake_pkg::*;

  logic        start;
  logic        dir_up;
  logic        dir_down;
  logic        dir_left;
  logic        dir_right;
  logic [31:0] apple_x;
  logic [31:0] apple_y;
  logic [31:0] head_x;
  logic [31:0] head_y;
  logic        collision;
  logic        game_over;
  logic [7:0]  length;

  modport master (
    output start, dir_up, dir_down, dir_left, dir_right, apple_x, apple_y,
    input  head_x, head_y, collision, game_over, length
  );

  modport slave (
    input  start, dir_up, dir_down, dir_left, dir_right, apple_x, apple_y,
    output head_x, head_y, collision, game_over, length
  );

endinterface

// File: rtl/step_timer.sv
// Free-running step interval counter: counts 0..STEP_CYCLES-1 while enabled,
// pulses step on the last count, and sits at 0 when disabled or cleared.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 2500000
) (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam int unsigned W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      count <= '0;
    else if (clear || !enable || count == LAST)
      count <= '0;
    else
      count <= count + W'(1);
  end

  assign step = enable && !clear && (count == LAST);

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: steps the head across the playfield under button
// control, flags apple overlap, tracks length and wall-hit game over.
//
// state | meaning
// IDLE  | after reset, head parked at start position, waiting for start
// RUN   | play: direction latch, periodic steps, apple collision
// DEAD  | wall hit, head frozen, game_over high, waiting for start
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter logic [31:0] START_X     = 32'd320,
  parameter logic [31:0] START_Y     = 32'd224,
  parameter int unsigned MAX_LEN     = 32
) (
  input  logic              clk,
  input  logic              resetN,
  snake_head_ctrl_if.slave  bus
);

  state_t      state, state_n;
  dir_t        cur_dir, cur_dir_n, pend_dir, pend_dir_n, req_dir;
  logic [31:0] head_x, head_x_n, head_y, head_y_n, mv_x, mv_y;
  logic        collision, collision_n, overlap, req_valid, wall_hit;
  logic        step, timer_clr;
  logic [7:0]  length, length_n;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .clk    (clk),
    .resetN (resetN),
    .enable (state == RUN),
    .clear  (timer_clr),
    .step   (step)
  );

  assign req_valid = bus.dir_up | bus.dir_down | bus.dir_left | bus.dir_right;
  assign req_dir   = bus.dir_up ? UP : bus.dir_down ? DOWN : bus.dir_left ? LEFT : RIGHT;

  assign overlap = (head_x + CELL > bus.apple_x) && (bus.apple_x + CELL > head_x) &&
                   (head_y + CELL > bus.apple_y) && (bus.apple_y + CELL > head_y);

  // Left/up walls are tested before subtracting so a move off 0 never wraps.
  always_comb begin
    mv_x     = head_x;
    mv_y     = head_y;
    wall_hit = 1'b0;
    case (pend_dir)
      UP:      begin wall_hit = (head_y < CELL); mv_y = head_y - CELL; end
      DOWN:    begin mv_y = head_y + CELL; wall_hit = (mv_y > SCREEN_H - CELL); end
      LEFT:    begin wall_hit = (head_x < CELL); mv_x = head_x - CELL; end
      default: begin mv_x = head_x + CELL; wall_hit = (mv_x > SCREEN_W - CELL); end
    endcase
  end

  always_comb begin
    state_n     = state;
    head_x_n    = head_x;
    head_y_n    = head_y;
    cur_dir_n   = cur_dir;
    pend_dir_n  = pend_dir;
    length_n    = length;
    collision_n = 1'b0;
    timer_clr   = 1'b0;
    case (state)
      IDLE, DEAD: begin
        if (bus.start) begin
          state_n    = RUN;
          head_x_n   = START_X;
          head_y_n   = START_Y;
          length_n   = 8'd1;
          cur_dir_n  = RIGHT;
          pend_dir_n = RIGHT;
          timer_clr  = 1'b1;
        end
      end
      RUN: begin
        if (req_valid && req_dir != reverse_dir(cur_dir))
          pend_dir_n = req_dir;
        if (step) begin
          cur_dir_n = pend_dir;
          if (wall_hit) begin
            state_n = DEAD;
          end else begin
            head_x_n = mv_x;
            head_y_n = mv_y;
          end
        end
        // Gating on the next state keeps collision low throughout DEAD.
        collision_n = overlap && (state_n == RUN);
        if (collision_n && !collision && length < 8'(MAX_LEN))
          length_n = length + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      head_x    <= START_X;
      head_y    <= START_Y;
      cur_dir   <= RIGHT;
      pend_dir  <= RIGHT;
      collision <= 1'b0;
      length    <= 8'd1;
    end else begin
      state     <= state_n;
      head_x    <= head_x_n;
      head_y    <= head_y_n;
      cur_dir   <= cur_dir_n;
      pend_dir  <= pend_dir_n;
      collision <= collision_n;
      length    <= length_n;
    end
  end

  assign bus.head_x    = head_x;
  assign bus.head_y    = head_y;
  assign bus.collision = collision;
  assign bus.game_over = (state == DEAD);
  assign bus.length    = length;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed bench for snake_head_ctrl with a 4-cycle step interval.
module tb_snake_head_ctrl;

  logic clk = 1'b0;
  logic resetN;
  int   n_vec = 0;
  int   n_err = 0;

  snake_head_ctrl_if bus ();

  snake_head_ctrl #(.STEP_CYCLES(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_apple(input logic [31:0] x, input logic [31:0] y);
    bus.apple_x = x;
    bus.apple_y = y;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick(2);
    resetN = 1'b1;
    tick(1);
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    resetN        = 1'b0;
    bus.start     = 1'b0;
    bus.dir_up    = 1'b0;
    bus.dir_down  = 1'b0;
    bus.dir_left  = 1'b0;
    bus.dir_right = 1'b0;
    set_apple(0, 0);
    #13;
    check_val("rst_head_x", bus.head_x, 320);
    check_val("rst_head_y", bus.head_y, 224);
    check_val("rst_length", 32'(bus.length), 1);
    check_val("rst_collision", 32'(bus.collision), 0);
    check_val("rst_game_over", 32'(bus.game_over), 0);
    resetN = 1'b1;
    tick(1);

    // 1: start and two steps right
    start_game();
    check_val("t1_start_x", bus.head_x, 320);
    check_val("t1_start_y", bus.head_y, 224);
    tick(4);
    check_val("t1_step1_x", bus.head_x, 352);
    tick(4);
    check_val("t1_step2_x", bus.head_x, 384);
    check_val("t1_length", 32'(bus.length), 1);
    check_val("t1_collision", 32'(bus.collision), 0);

    // 2: reversal ignored, then up pulse mid-interval, then reversal of up ignored
    bus.dir_left = 1'b1;
    tick(4);
    check_val("t2_rev_x", bus.head_x, 416);
    check_val("t2_rev_y", bus.head_y, 224);
    bus.dir_left = 1'b0;
    tick(2);
    bus.dir_up = 1'b1;
    tick(1);
    bus.dir_up = 1'b0;
    tick(1);
    check_val("t2_up_y", bus.head_y, 192);
    check_val("t2_up_x", bus.head_x, 416);
    bus.dir_down = 1'b1;
    tick(4);
    bus.dir_down = 1'b0;
    check_val("t2_down_ign_y", bus.head_y, 160);

    // 3: apple collision, hold, start in RUN ignored, apple moves away
    set_apple(384, 224);
    do_reset();
    start_game();
    check_val("t3_no_ovl0", 32'(bus.collision), 0);
    tick(4);
    check_val("t3_x352", bus.head_x, 352);
    tick(4);
    check_val("t3_x384", bus.head_x, 384);
    check_val("t3_coll_lat", 32'(bus.collision), 0);
    tick(1);
    check_val("t3_coll", 32'(bus.collision), 1);
    check_val("t3_len2", 32'(bus.length), 2);
    bus.start = 1'b1;
    tick(3);
    bus.start = 1'b0;
    check_val("t3_hold_x", bus.head_x, 416);
    check_val("t3_hold_coll", 32'(bus.collision), 1);
    check_val("t3_hold_len", 32'(bus.length), 2);
    set_apple(0, 0);
    tick(1);
    check_val("t3_away_coll", 32'(bus.collision), 0);
    check_val("t3_away_len", 32'(bus.length), 2);

    // 4: right wall at x=608 with apple on the head
    do_reset();
    start_game();
    tick(36);
    check_val("t4_x608", bus.head_x, 608);
    set_apple(608, 224);
    tick(1);
    check_val("t4_coll", 32'(bus.collision), 1);
    check_val("t4_len2", 32'(bus.length), 2);
    tick(3);
    check_val("t4_dead_x", bus.head_x, 608);
    check_val("t4_dead_go", 32'(bus.game_over), 1);
    check_val("t4_dead_coll", 32'(bus.collision), 0);
    check_val("t4_dead_len", 32'(bus.length), 2);
    tick(3);
    check_val("t4_frozen_x", bus.head_x, 608);
    start_game();
    check_val("t4_restart_x", bus.head_x, 320);
    check_val("t4_restart_y", bus.head_y, 224);
    check_val("t4_restart_len", 32'(bus.length), 1);
    check_val("t4_restart_go", 32'(bus.game_over), 0);
    set_apple(0, 0);

    // 5: top wall, no wrap (still at phase 0 right after restart)
    bus.dir_up = 1'b1;
    tick(1);
    bus.dir_up = 1'b0;
    tick(3);
    check_val("t5_y192", bus.head_y, 192);
    check_val("t5_x320", bus.head_x, 320);
    tick(24);
    check_val("t5_y0", bus.head_y, 0);
    check_val("t5_alive", 32'(bus.game_over), 0);
    tick(4);
    check_val("t5_dead_y", bus.head_y, 0);
    check_val("t5_dead_go", 32'(bus.game_over), 1);

    // 6: grow to 5, then async reset mid-interval
    start_game();
    set_apple(320, 224); tick(1);
    check_val("t6_len2", 32'(bus.length), 2);
    set_apple(0, 0);     tick(1);
    set_apple(320, 224); tick(1);
    set_apple(0, 0);     tick(1);
    check_val("t6_x352", bus.head_x, 352);
    set_apple(352, 224); tick(1);
    set_apple(0, 0);     tick(1);
    set_apple(352, 224); tick(1);
    set_apple(0, 0);     tick(1);
    check_val("t6_len5", 32'(bus.length), 5);
    check_val("t6_x384", bus.head_x, 384);
    tick(1);
    #2;
    resetN = 1'b0;
    #1;
    check_val("t6_rst_x", bus.head_x, 320);
    check_val("t6_rst_y", bus.head_y, 224);
    check_val("t6_rst_len", 32'(bus.length), 1);
    check_val("t6_rst_coll", 32'(bus.collision), 0);
    check_val("t6_rst_go", 32'(bus.game_over), 0);
    resetN = 1'b1;
    tick(20);
    check_val("t6_idle_x", bus.head_x, 320);
    check_val("t6_idle_y", bus.head_y, 224);
    check_val("t6_idle_len", 32'(bus.length), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
